// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, register-index constants and common typedefs.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_select.sv
// Write-back source mux: picks the loaded memory word or the ALU result.
module wb_select #(
  parameter int DATA_W = 32
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data
);

  // mem_to_reg chooses between the load result and the ALU result
  always_comb begin
    wb_data = alu_result;
    if (mem_to_reg) begin
      wb_data = read_data;
    end else begin
      wb_data = alu_result;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32-entry architectural register file with retired-write counter.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-before-read forwarding on both read ports.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_back_in,
  input  logic              mem_to_reg_in,
  input  logic [ADDR_W-1:0] write_reg_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] address_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [CNT_W-1:0]  retire_cnt_r;
  logic [DATA_W-1:0] wb_data_s;
  logic              wb_commit_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  wb_select #(
    .DATA_W (DATA_W)
  ) u_wb_select (
    .mem_to_reg (mem_to_reg_in),
    .read_data  (read_data_in),
    .alu_result (address_in),
    .wb_data    (wb_data_s)
  );

  // Writes to register 0 never commit and are never counted
  always_comb begin
    wb_commit_s = 1'b0;
    if (write_back_in && (write_reg_in != ZERO_IDX)) begin
      wb_commit_s = 1'b1;
    end else begin
      wb_commit_s = 1'b0;
    end
  end

  // Register array write port; reset clears every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_commit_s) begin
      regs_r[write_reg_in] <= wb_data_s;
    end
  end

  // Retired-write counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (wb_commit_s) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read port A: register 0 hardwired to zero, optional same-cycle forwarding
  always_comb begin
    rs_data_s = {DATA_W{1'b0}};
    if (rs_addr == ZERO_IDX) begin
      rs_data_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wb_commit_s && (rs_addr == write_reg_in)) begin
      rs_data_s = wb_data_s;
`endif
    end else begin
      rs_data_s = regs_r[rs_addr];
    end
  end

  // Read port B: same rules as port A
  always_comb begin
    rt_data_s = {DATA_W{1'b0}};
    if (rt_addr == ZERO_IDX) begin
      rt_data_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wb_commit_s && (rt_addr == write_reg_in)) begin
      rt_data_s = wb_data_s;
`endif
    end else begin
      rt_data_s = regs_r[rt_addr];
    end
  end

  assign rs_data    = rs_data_s;
  assign rt_data    = rt_data_s;
  assign wb_data    = wb_data_s;
  assign wb_commit  = wb_commit_s;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (counter width reduced to 4 to exercise wrap).
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        write_back_in;
  logic        mem_to_reg_in;
  logic [4:0]  write_reg_in;
  logic [31:0] read_data_in;
  logic [31:0] address_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_commit;
  logic [3:0]  retire_cnt;

  int checks;
  int failures;

  wb_regfile #(
    .DATA_W (32),
    .ADDR_W (5),
    .CNT_W  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_back_in (write_back_in),
    .mem_to_reg_in (mem_to_reg_in),
    .write_reg_in  (write_reg_in),
    .read_data_in  (read_data_in),
    .address_in    (address_in),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_commit     (wb_commit),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one write-back request at the falling edge (stimulus only).
  task automatic drive(input logic wb, input logic m2r, input logic [4:0] wr,
                       input logic [31:0] rd, input logic [31:0] alu);
    @(negedge clk);
    write_back_in = wb;
    mem_to_reg_in = m2r;
    write_reg_in  = wr;
    read_data_in  = rd;
    address_in    = alu;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    rs_addr = 5'd8;
    rt_addr = 5'd31;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rs: got %h expected %h", rs_data, 32'h0);
    end
    checks++;
    if (rt_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rt: got %h expected %h", rt_data, 32'h0);
    end
    checks++;
    if (retire_cnt !== 4'h0) begin
      failures++;
      $display("FAIL reset_cnt: got %h expected %h", retire_cnt, 4'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_path();
    drive(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 32'h00001000);
    checks++;
    if (wb_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_wb_data: got %h expected %h", wb_data, 32'hDEADBEEF);
    end
    checks++;
    if (wb_commit !== 1'b1) begin
      failures++;
      $display("FAIL load_commit: got %b expected %b", wb_commit, 1'b1);
    end
    rs_addr = 5'd8;
    @(posedge clk);
    #1;
    checks++;
    if (rs_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_rs: got %h expected %h", rs_data, 32'hDEADBEEF);
    end
    checks++;
    if (retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL load_cnt: got %h expected %h", retire_cnt, 4'd1);
    end
  endtask

  task automatic test_alu_path();
    drive(1'b1, 1'b0, 5'd9, 32'hCAFEF00D, 32'h00000042);
    checks++;
    if (wb_data !== 32'h00000042) begin
      failures++;
      $display("FAIL alu_wb_data: got %h expected %h", wb_data, 32'h00000042);
    end
    rt_addr = 5'd9;
    @(posedge clk);
    #1;
    checks++;
    if (rt_data !== 32'h00000042) begin
      failures++;
      $display("FAIL alu_rt: got %h expected %h", rt_data, 32'h00000042);
    end
    checks++;
    if (retire_cnt !== 4'd2) begin
      failures++;
      $display("FAIL alu_cnt: got %h expected %h", retire_cnt, 4'd2);
    end
  endtask

  task automatic test_reg_zero();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF);
    rs_addr = 5'd0;
    #1;
    checks++;
    if (wb_commit !== 1'b0) begin
      failures++;
      $display("FAIL zero_commit: got %b expected %b", wb_commit, 1'b0);
    end
    checks++;
    if (rs_data !== 32'h0) begin
      failures++;
      $display("FAIL zero_rs_same: got %h expected %h", rs_data, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      failures++;
      $display("FAIL zero_rs_after: got %h expected %h", rs_data, 32'h0);
    end
    checks++;
    if (retire_cnt !== 4'd2) begin
      failures++;
      $display("FAIL zero_cnt: got %h expected %h", retire_cnt, 4'd2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h00000022;
`else
    exp_same = 32'h00000011;
`endif
    drive(1'b1, 1'b0, 5'd5, 32'h0, 32'h00000011);
    @(posedge clk);
    drive(1'b1, 1'b0, 5'd5, 32'h0, 32'h00000022);
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    #1;
    checks++;
    if (rs_data !== exp_same) begin
      failures++;
      $display("FAIL same_rs: got %h expected %h", rs_data, exp_same);
    end
    checks++;
    if (rt_data !== exp_same) begin
      failures++;
      $display("FAIL same_rt: got %h expected %h", rt_data, exp_same);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rs_data !== 32'h00000022) begin
      failures++;
      $display("FAIL same_rs_after: got %h expected %h", rs_data, 32'h00000022);
    end
    checks++;
    if (retire_cnt !== 4'd4) begin
      failures++;
      $display("FAIL same_cnt: got %h expected %h", retire_cnt, 4'd4);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 5'd10, 32'h12345678, 32'h0);
    @(posedge clk);
    drive(1'b1, 1'b0, 5'd11, 32'h0, 32'h87654321);
    #2 rst_n = 1'b0;
    rs_addr = 5'd8;
    rt_addr = 5'd10;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_rs8: got %h expected %h", rs_data, 32'h0);
    end
    checks++;
    if (rt_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_rt10: got %h expected %h", rt_data, 32'h0);
    end
    checks++;
    if (retire_cnt !== 4'd0) begin
      failures++;
      $display("FAIL mid_cnt: got %h expected %h", retire_cnt, 4'd0);
    end
    @(posedge clk);
    #1;
    rs_addr = 5'd11;
    #1;
    checks++;
    if (rs_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_lost_write: got %h expected %h", rs_data, 32'h0);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (retire_cnt !== 4'd0) begin
      failures++;
      $display("FAIL mid_cnt_after: got %h expected %h", retire_cnt, 4'd0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd7, 32'h0, 32'h00000077);
      @(posedge clk);
    end
    #1;
    checks++;
    if (retire_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wrap_idle_cnt: got %h expected %h", retire_cnt, 4'd0);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 5'(i + 1), 32'h0, 32'h00000100 + 32'(i));
      @(posedge clk);
      #1;
      if (i == 14) begin
        checks++;
        if (retire_cnt !== 4'd15) begin
          failures++;
          $display("FAIL wrap_cnt_15: got %h expected %h", retire_cnt, 4'd15);
        end
      end
    end
    checks++;
    if (retire_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wrap_cnt_0: got %h expected %h", retire_cnt, 4'd0);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs_addr = 5'd16;
    rt_addr = 5'd1;
    #1;
    checks++;
    if (rs_data !== 32'h0000010F) begin
      failures++;
      $display("FAIL wrap_rs16: got %h expected %h", rs_data, 32'h0000010F);
    end
    checks++;
    if (rt_data !== 32'h00000100) begin
      failures++;
      $display("FAIL wrap_rt1: got %h expected %h", rt_data, 32'h00000100);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    write_back_in = 1'b0;
    mem_to_reg_in = 1'b0;
    write_reg_in  = 5'd0;
    read_data_in  = 32'h0;
    address_in    = 32'h0;
    rs_addr       = 5'd0;
    rt_addr       = 5'd0;
    test_reset();
    test_load_path();
    test_alu_path();
    test_reg_zero();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
